// File: rtl/uart_echo_pkg.sv
// Shared types for the UART echo controller.
// Mode, transform and FSM encodings used by the top and the transform unit.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_PAUSE  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_INV  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int DBIT_DEF   = 8;
  localparam int OFFSET_DEF = 1;
  localparam int CNT_W_DEF  = 16;
  localparam int PEND_W_DEF = 3;

endpackage

// File: rtl/uart_echo_xform.sv
// Byte transform applied between receive pop and transmit push.
// Arithmetic wraps modulo 2^DBIT.
module uart_echo_xform
  import uart_echo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int OFFSET = OFFSET_DEF
) (
  input  logic [1:0]      op_sel,
  input  logic [DBIT-1:0] din,
  output logic [DBIT-1:0] dout
);

  localparam logic [DBIT-1:0] OFF = DBIT'(OFFSET);

  always_comb begin
    dout = din;
    unique case (op_t'(op_sel))
      OP_PASS: dout = din;
      OP_ADD:  dout = din + OFF;
      OP_INV:  dout = ~din;
      OP_SUB:  dout = din - OFF;
    endcase
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// UART FIFO loopback controller: pop, transform, push.
// Manual (button-paced), auto (free-running) or paused operation.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int OFFSET = OFFSET_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [1:0]        op_sel,
  input  logic              step_tick,
  input  logic              rx_empty,
  input  logic [DBIT-1:0]   r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [DBIT-1:0]   w_data,
  output logic              wr_uart,
  output logic [DBIT-1:0]   last_rx,
  output logic [DBIT-1:0]   last_tx,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [PEND_W-1:0] pending,
  output logic              busy
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t          state;
  logic [DBIT-1:0] hold;
  logic [DBIT-1:0] xf;
  logic            is_auto;
  logic            is_manual;
  logic            grant;
  logic            man_dec;
  logic            pend_inc;

  uart_echo_xform #(
    .DBIT   (DBIT),
    .OFFSET (OFFSET)
  ) u_xform (
    .op_sel (op_sel),
    .din    (r_data),
    .dout   (xf)
  );

  always_comb begin
    is_auto   = 1'b0;
    is_manual = 1'b0;
    unique case (mode_t'(mode))
      MODE_MANUAL: is_manual = 1'b1;
      MODE_AUTO:   is_auto   = 1'b1;
      default:     ;
    endcase
  end

  assign grant = (state == ST_IDLE) && !rx_empty &&
                 (is_auto || (is_manual && pending != '0));

  assign man_dec  = grant && is_manual;
  assign pend_inc = step_tick && pending != PEND_MAX;

  // Strobes are masked during reset so a held byte is dropped cleanly.
  assign rd_uart = grant && !reset;
  assign wr_uart = (state == ST_SEND) && !tx_full && !reset;
  assign busy    = (state == ST_SEND);
  assign w_data  = hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold       <= '0;
      last_rx    <= '0;
      last_tx    <= '0;
      xfer_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant) begin
            hold    <= xf;
            last_rx <= r_data;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_full) begin
            last_tx    <= hold;
            xfer_count <= xfer_count + CNT_W'(1);
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // A tick that coincides with a manual grant leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (step_tick && man_dec) begin
      pending <= pending;
    end else if (pend_inc) begin
      pending <= pending + PEND_W'(1);
    end else if (man_dec) begin
      pending <= pending - PEND_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl with a queue-based FIFO model.
// Small counter widths so wrap and saturation are reachable.
module tb_uart_echo_ctrl;

  localparam int DBIT   = 8;
  localparam int CNT_W  = 4;
  localparam int PEND_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic [1:0]        op_sel;
  logic              step_tick;
  logic              rx_empty;
  logic [DBIT-1:0]   r_data;
  logic              rd_uart;
  logic              tx_full;
  logic [DBIT-1:0]   w_data;
  logic              wr_uart;
  logic [DBIT-1:0]   last_rx;
  logic [DBIT-1:0]   last_tx;
  logic [CNT_W-1:0]  xfer_count;
  logic [PEND_W-1:0] pending;
  logic              busy;

  uart_echo_ctrl #(
    .DBIT   (DBIT),
    .OFFSET (1),
    .CNT_W  (CNT_W),
    .PEND_W (PEND_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .op_sel     (op_sel),
    .step_tick  (step_tick),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .tx_full    (tx_full),
    .w_data     (w_data),
    .wr_uart    (wr_uart),
    .last_rx    (last_rx),
    .last_tx    (last_tx),
    .xfer_count (xfer_count),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [7:0] got_q[$];

  logic              m_send = 1'b0;
  logic [PEND_W-1:0] pend_m = '0;
  logic [CNT_W-1:0]  cnt_m  = '0;
  logic [7:0]        lrx_m  = '0;
  logic [7:0]        ltx_m  = '0;
  int                n_rd   = 0;
  int                n_wr   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_xf(input logic [1:0] op,
                                        input logic [7:0] d);
    case (op)
      2'b00:   return d;
      2'b01:   return 8'((int'(d) + 1) % 256);
      2'b10:   return 8'(255 - int'(d));
      default: return 8'((int'(d) + 255) % 256);
    endcase
  endfunction

  function automatic void refresh();
    rx_empty = (rxq.size() == 0);
    r_data   = (rxq.size() != 0) ? rxq[0] : 8'($urandom);
  endfunction

  // One clock: check outputs at negedge, advance model, pop FIFO model.
  task automatic cyc();
    logic allow, e_rd, e_wr, dec, pop;
    @(negedge clk);
    allow = (mode == 2'b01) || (mode == 2'b00 && pend_m != 0);
    e_rd  = !reset && !m_send && rxq.size() != 0 && allow;
    e_wr  = !reset && m_send && !tx_full;
    chk("rd_uart", rd_uart, e_rd);
    chk("wr_uart", wr_uart, e_wr);
    chk("rd_wr_excl", rd_uart && wr_uart, 0);
    chk("busy", busy, m_send);
    chk("pending", pending, pend_m);
    chk("xfer_count", xfer_count, cnt_m);
    chk("last_rx", last_rx, lrx_m);
    chk("last_tx", last_tx, ltx_m);
    if (rd_uart) n_rd++;
    if (wr_uart) begin
      n_wr++;
      got_q.push_back(w_data);
    end
    if (reset) begin
      m_send = 0; pend_m = 0; cnt_m = 0; lrx_m = 0; ltx_m = 0;
      expq.delete();
    end else begin
      dec = e_rd && mode == 2'b00;
      if (e_rd) begin
        expq.push_back(ref_xf(op_sel, rxq[0]));
        lrx_m  = rxq[0];
        m_send = 1;
      end else if (e_wr) begin
        if (expq.size() == 0) chk("exp_empty", 1, 0);
        else begin
          chk("w_data", w_data, expq[0]);
          ltx_m = expq.pop_front();
        end
        cnt_m  = cnt_m + 1'b1;
        m_send = 0;
      end
      if (step_tick && !dec && pend_m != 7) pend_m = pend_m + 1'b1;
      else if (!step_tick && dec) pend_m = pend_m - 1'b1;
    end
    pop = rd_uart;
    @(posedge clk);
    #1;
    if (pop && rxq.size() != 0) void'(rxq.pop_front());
    step_tick = 1'b0;
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  vec_t vecs[8];

  initial begin
    int nw;
    vecs[0] = '{2'b01, 8'h41, 8'h42};
    vecs[1] = '{2'b01, 8'hFF, 8'h00};
    vecs[2] = '{2'b11, 8'h00, 8'hFF};
    vecs[3] = '{2'b10, 8'h5A, 8'hA5};
    vecs[4] = '{2'b00, 8'h5A, 8'h5A};
    vecs[5] = '{2'b11, 8'h10, 8'h0F};
    vecs[6] = '{2'b10, 8'h00, 8'hFF};
    vecs[7] = '{2'b01, 8'h7F, 8'h80};

    reset = 1'b1; mode = 2'b01; op_sel = 2'b01;
    step_tick = 1'b0; tx_full = 1'b0;
    rxq.push_back(8'h41);
    refresh();
    @(posedge clk); #1;

    // Reset held with data waiting: nothing moves
    run(2);
    chk("rst_w_data", w_data, 0);
    reset = 1'b0;

    // First pop right after reset, push next cycle
    cyc();
    chk("t2_busy", busy, 1);
    cyc();
    chk("t2_last_rx", last_rx, 8'h41);
    chk("t2_last_tx", last_tx, 8'h42);
    chk("t2_count", xfer_count, 1);
    chk("t2_got", got_q.size() != 0 ? got_q[0] : 8'hxx, 8'h42);

    // Back-pressure stall
    op_sel = 2'b00; tx_full = 1'b1;
    rxq.push_back(8'h5A); rxq.push_back(8'h11);
    refresh();
    got_q.delete();
    nw = n_rd;
    run(12);
    chk("t3_pops", n_rd - nw, 1);
    chk("t3_pushes", got_q.size(), 0);
    chk("t3_busy", busy, 1);
    tx_full = 1'b0;
    run(6);
    chk("t3_cnt", got_q.size(), 2);
    chk("t3_first", got_q.size() != 0 ? got_q[0] : 8'hxx, 8'h5A);

    // Manual requests
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step_tick = 1'b1;
      cyc();
    end
    run(2);
    chk("t4_pend3", pending, 3);
    got_q.delete();
    for (int i = 0; i < 5; i++) rxq.push_back(8'(8'h20 + i));
    refresh();
    run(20);
    chk("t4_left", rxq.size(), 2);
    chk("t4_pushes", got_q.size(), 3);
    chk("t4_pend0", pending, 0);
    mode = 2'b10;
    for (int i = 0; i < 9; i++) begin
      step_tick = 1'b1;
      cyc();
    end
    chk("t4_sat", pending, 7);
    mode = 2'b01;
    run(6);
    chk("t4_auto_keep", pending, 7);

    // Transform table and counter wrap
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got_q.delete();
      op_sel = vecs[i].op;
      rxq.push_back(vecs[i].din);
      refresh();
      run(3);
      chk($sformatf("vec%0d", i),
          got_q.size() != 0 ? got_q[0] : 8'hxx, vecs[i].exp);
    end
    for (int i = 0; i < 9; i++) begin
      op_sel = 2'($urandom);
      rxq.push_back(8'($urandom));
      refresh();
      run(2);
    end
    run(2);
    chk("t5_wrap", xfer_count, 1);

    // Reset while stalled in SEND
    reset = 1'b1; cyc(); reset = 1'b0;
    tx_full = 1'b1;
    rxq.push_back(8'h33);
    refresh();
    run(3);
    chk("t6_busy", busy, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    tx_full = 1'b0;
    nw = n_wr;
    run(3);
    chk("t6_nowr", n_wr - nw, 0);
    chk("t6_idle", busy, 0);
    chk("t6_ltx", last_tx, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      mode      = 2'($urandom);
      op_sel    = 2'($urandom);
      step_tick = ($urandom_range(0, 3) == 0);
      tx_full   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0 && rxq.size() < 8)
        rxq.push_back(8'($urandom));
      refresh();
      cyc();
    end
    mode = 2'b01; tx_full = 1'b0;
    run(24);
    chk("drain_rx", rxq.size(), 0);
    chk("drain_tx", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
